// File: rtl/audio_defs_pkg.sv
// Shared audio constants for the PDM playback and capture paths.
package audio_defs_pkg;

    localparam int unsigned SAMPLE_W    = 16;
    localparam int unsigned MIC_CLK_DIV = 100;
    localparam int unsigned OSR         = 64;

    // Offset-binary midscale, equivalent to PCM zero.
    localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'h8000;

    typedef logic [SAMPLE_W-1:0] pcm_t;

endpackage

// File: rtl/pdm_tick_gen.sv
// Divides the system clock down to a one-cycle modulator/microphone tick.
module pdm_tick_gen #(
    parameter int unsigned CLK_DIV = audio_defs_pkg::MIC_CLK_DIV
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] div_cnt_q;

    // Free-running divider, held at zero while disabled so re-enable has fixed latency.
    always_ff @(posedge clock_i) begin
        if (reset_i || !enable_i) begin
            div_cnt_q <= '0;
        end else if (div_cnt_q == CntMax) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    assign tick_o = enable_i & (div_cnt_q == CntMax);

endmodule

// File: rtl/pdm_audio_tx.sv
// PCM playback: one-entry sample buffer feeding a first-order sigma-delta PDM modulator.
module pdm_audio_tx #(
    parameter int unsigned CLK_DIV  = audio_defs_pkg::MIC_CLK_DIV,
    parameter int unsigned OSR      = audio_defs_pkg::OSR,
    parameter int unsigned SAMPLE_W = audio_defs_pkg::SAMPLE_W
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                sample_valid_i,
    output logic                sample_ready_o,
    output logic                pdm_o,
    output logic                aud_sd_o,
    output logic                underrun_o
);

    localparam int unsigned OsrW = $clog2(OSR);
    localparam logic [OsrW-1:0] OsrMax = OsrW'(OSR - 1);
    localparam logic [SAMPLE_W-1:0] MidScale = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic                tick;
    logic                frame_start;
    logic                push;
    logic [SAMPLE_W-1:0] sample_u;

    logic                buf_full_q, buf_full_d;
    logic [SAMPLE_W-1:0] buf_data_q, buf_data_d;
    logic [SAMPLE_W-1:0] cur_q, cur_d;       // offset binary
    logic [SAMPLE_W-1:0] acc_q, acc_d;
    logic [SAMPLE_W-1:0] acc_sum;
    logic                carry;
    logic [OsrW-1:0]     osr_cnt_q, osr_cnt_d;
    logic                pdm_q, pdm_d;
    logic                underrun_q, underrun_d;
    logic                ready_q;
    logic                aud_sd_q;

    pdm_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .enable_i(enable_i),
        .tick_o  (tick)
    );

    assign push        = sample_valid_i & ready_q;
    assign frame_start = tick & (osr_cnt_q == '0);
    assign sample_u    = {~sample_i[SAMPLE_W-1], sample_i[SAMPLE_W-2:0]};

    // Buffer and current-sample selection; a push on an empty-buffer frame start bypasses.
    always_comb begin
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        cur_d      = cur_q;
        underrun_d = 1'b0;
        if (frame_start) begin
            if (buf_full_q) begin
                cur_d      = buf_data_q;
                buf_full_d = push;
                if (push) begin
                    buf_data_d = sample_u;
                end
            end else if (push) begin
                cur_d = sample_u;
            end else begin
                cur_d      = MidScale;
                underrun_d = 1'b1;
            end
        end else if (push) begin
            buf_full_d = 1'b1;
            buf_data_d = sample_u;
        end
        if (!enable_i) begin
            cur_d = MidScale;
        end
    end

    // Sigma-delta step: accumulator carry is the output bit; frame counter runs on ticks.
    always_comb begin
        {carry, acc_sum} = {1'b0, acc_q} + {1'b0, cur_d};
        acc_d     = acc_q;
        pdm_d     = pdm_q;
        osr_cnt_d = osr_cnt_q;
        if (!enable_i) begin
            acc_d     = '0;
            pdm_d     = 1'b0;
            osr_cnt_d = '0;
        end else if (tick) begin
            acc_d     = acc_sum;
            pdm_d     = carry;
            osr_cnt_d = (osr_cnt_q == OsrMax) ? '0 : osr_cnt_q + 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
            cur_q      <= MidScale;
            acc_q      <= '0;
            osr_cnt_q  <= '0;
            pdm_q      <= 1'b0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b0;
            aud_sd_q   <= 1'b0;
        end else begin
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
            cur_q      <= cur_d;
            acc_q      <= acc_d;
            osr_cnt_q  <= osr_cnt_d;
            pdm_q      <= pdm_d;
            underrun_q <= underrun_d;
            ready_q    <= ~buf_full_d;
            aud_sd_q   <= enable_i;
        end
    end

    assign sample_ready_o = ready_q;
    assign pdm_o          = pdm_q;
    assign aud_sd_o       = aud_sd_q;
    assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_pdm_audio_tx.sv
// Self-checking bench for pdm_audio_tx with default CLK_DIV=100, OSR=64.
module tb_pdm_audio_tx;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        pdm;
    logic        aud_sd;
    logic        underrun;

    int          cyc = 0;
    int          base = 0;
    int          checks = 0;
    int          errors = 0;
    int          acc_m = 0;
    logic [63:0] got = '0;
    logic [15:0] sa, sb, sc, sd, se, sf;

    pdm_audio_tx dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .enable_i      (enable),
        .sample_i      (sample),
        .sample_valid_i(sample_valid),
        .sample_ready_o(sample_ready),
        .pdm_o         (pdm),
        .aud_sd_o      (aud_sd),
        .underrun_o    (underrun)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Edge index (from enable/reset release) of tick k in frame f.
    function automatic int te(input int f, input int k);
        return 99 + 100 * (64 * f + k);
    endfunction

    task automatic goto_edge(input int e);
        if (cyc - base > e) begin
            checks++;
            errors++;
            $display("FAIL timing: at edge %0d, required edge %0d", cyc - base, e);
        end
        while (cyc - base < e) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic grab(input int f, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            goto_edge(te(f, k));
            got[k] = pdm;
        end
    endtask

    task automatic push(input logic [15:0] s);
        int w;
        w = 0;
        sample = s;
        sample_valid = 1'b1;
        while (!sample_ready && w < 20000) begin
            @(posedge clock);
            #1;
            w++;
        end
        if (!sample_ready) begin
            errors++;
            $display("FAIL push_timeout: ready=%b required 1", sample_ready);
        end
        @(posedge clock);
        #1;
        sample_valid = 1'b0;
    endtask

    // Reference: bit k is the change in floor((acc0 + k*u) / 2^16).
    task automatic check_frame(input string name, input logic [15:0] s, input int n,
                               input int exp_ones);
        logic [63:0] exp_bits;
        logic [63:0] mask;
        int          u;
        int          ones;
        u = int'(s ^ 16'h8000);
        exp_bits = '0;
        for (int k = 0; k < n; k++) begin
            exp_bits[k] = (((acc_m + (k + 1) * u) >> 16) - ((acc_m + k * u) >> 16)) != 0;
        end
        mask = (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        checks++;
        if ((got & mask) !== exp_bits) begin
            errors++;
            $display("FAIL %s bits: got %h required %h", name, got & mask, exp_bits);
        end
        if (exp_ones >= 0) begin
            ones = $countones(got & mask);
            checks++;
            if (ones != exp_ones) begin
                errors++;
                $display("FAIL %s ones: got %0d required %0d", name, ones, exp_ones);
            end
        end
        acc_m = (acc_m + n * u) & 32'hFFFF;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (pdm !== 1'b0) begin errors++; $display("FAIL rst_pdm: got %b required 0", pdm); end
        checks++; if (aud_sd !== 1'b0) begin errors++; $display("FAIL rst_sd: got %b required 0", aud_sd); end
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", sample_ready); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b required 0", underrun); end
        reset = 1'b0;
        @(posedge clock);
        #1;
        base = cyc;
        acc_m = 0;
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b required 1", sample_ready); end
        checks++; if (aud_sd !== 1'b1) begin errors++; $display("FAIL rel_sd: got %b required 1", aud_sd); end
    endtask

    task automatic test_zero_sample();
        push(16'h0000);
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL buf_full_ready: got %b required 0", sample_ready); end
        grab(0, 0, 0);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL zero_underrun: got %b required 0", underrun); end
        push(16'h7FFF);
        grab(0, 1, 63);
        check_frame("zero", 16'h0000, 64, 32);
        checks++;
        if (got !== 64'hAAAA_AAAA_AAAA_AAAA) begin
            errors++;
            $display("FAIL zero_pattern: got %h required aaaaaaaaaaaaaaaa", got);
        end
    endtask

    task automatic test_full_scale();
        grab(1, 0, 0);
        push(16'h8000);
        grab(1, 1, 63);
        check_frame("full_pos", 16'h7FFF, 64, 63);
        checks++; if (got[0] !== 1'b0) begin errors++; $display("FAIL full_pos_first: got %b required 0", got[0]); end
        grab(2, 0, 63);
        check_frame("full_neg", 16'h8000, 64, 0);
    endtask

    task automatic test_underrun();
        goto_edge(te(3, 0) - 1);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_pre: got %b required 0", underrun); end
        goto_edge(te(3, 0));
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_pulse: got %b required 1", underrun); end
        got[0] = pdm;
        sa = 16'($urandom);
        sb = 16'($urandom);
        push(sa);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_width: got %b required 0", underrun); end
        sample = sb;
        sample_valid = 1'b1;
        grab(3, 1, 31);
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b required 0", sample_ready); end
        grab(3, 32, 63);
        check_frame("underrun", 16'h0000, 64, 32);
    endtask

    task automatic test_back_to_back();
        goto_edge(te(4, 0));
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b required 1", sample_ready); end
        got[0] = pdm;
        @(posedge clock);
        #1;
        sample_valid = 1'b0;
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL b2b_taken: got %b required 0", sample_ready); end
        grab(4, 1, 63);
        check_frame("b2b_first", sa, 64, -1);
        grab(5, 0, 63);
        check_frame("b2b_second", sb, 64, -1);
    endtask

    task automatic test_coincident();
        goto_edge(te(6, 0) - 1);
        sc = 16'($urandom);
        sample = sc;
        sample_valid = 1'b1;
        goto_edge(te(6, 0));
        sample_valid = 1'b0;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL coinc_underrun: got %b required 0", underrun); end
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL coinc_ready: got %b required 1", sample_ready); end
        got[0] = pdm;
        sd = 16'($urandom);
        push(sd);
        grab(6, 1, 63);
        check_frame("coincident", sc, 64, -1);
    endtask

    task automatic test_enable();
        grab(7, 0, 31);
        check_frame("pre_disable", sd, 32, -1);
        goto_edge(te(7, 31) + 50);
        enable = 1'b0;
        @(posedge clock);
        #1;
        checks++; if (pdm !== 1'b0) begin errors++; $display("FAIL dis_pdm: got %b required 0", pdm); end
        checks++; if (aud_sd !== 1'b0) begin errors++; $display("FAIL dis_sd: got %b required 0", aud_sd); end
        se = 16'($urandom);
        push(se);
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL preload_ready: got %b required 0", sample_ready); end
        repeat (300) @(posedge clock);
        #1;
        checks++; if (pdm !== 1'b0) begin errors++; $display("FAIL dis_hold_pdm: got %b required 0", pdm); end
        enable = 1'b1;
        @(posedge clock);
        #1;
        base = cyc;
        acc_m = 0;
        checks++; if (aud_sd !== 1'b1) begin errors++; $display("FAIL reen_sd: got %b required 1", aud_sd); end
        grab(0, 0, 0);
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reen_underrun: got %b required 0", underrun); end
        sf = 16'($urandom);
        push(sf);
        grab(0, 1, 31);
        check_frame("reenable", se, 32, -1);
    endtask

    task automatic test_reset_mid();
        goto_edge(te(0, 31) + 40);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (pdm !== 1'b0) begin errors++; $display("FAIL mid_rst_pdm: got %b required 0", pdm); end
        checks++; if (aud_sd !== 1'b0) begin errors++; $display("FAIL mid_rst_sd: got %b required 0", aud_sd); end
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b required 0", sample_ready); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL mid_rst_underrun: got %b required 0", underrun); end
        reset = 1'b0;
        @(posedge clock);
        #1;
        base = cyc;
        acc_m = 0;
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL buf_cleared: got %b required 1", sample_ready); end
        goto_edge(te(0, 0));
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL post_rst_underrun: got %b required 1", underrun); end
        got[0] = pdm;
        grab(0, 1, 63);
        check_frame("after_reset", 16'h0000, 64, 32);
    endtask

    initial begin
        test_reset();
        test_zero_sample();
        test_full_scale();
        test_underrun();
        test_back_to_back();
        test_coincident();
        test_enable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
